// File: rtl/br_arb_pkg.sv
// Shared helpers for the Bedrock prioritized round-robin arbiters: cyclic search and one-hot decode.
// Vectors are zero-extended to MaxRequesters bits by the caller, so one function serves every width.
package br_arb_pkg;

   localparam int MaxRequesters = 32;
   localparam int MaxIdxW       = 5;

   // First set bit of req strictly after ptr, wrapping from n-1 to 0; returns 0 when none is set.
   function automatic logic [MaxIdxW-1:0] rr_first_after(input logic [MaxRequesters-1:0] req,
                                                          input logic [MaxIdxW-1:0]       ptr,
                                                          input int                       n);
      logic [MaxIdxW-1:0] idx;
      logic               found;
      int                 j;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= MaxRequesters; k++) begin
         j = int'(ptr) + k;
         if (j >= n) j = j - n;
         if (k <= n && j < MaxRequesters && !found && req[j[MaxIdxW-1:0]]) begin
            idx   = j[MaxIdxW-1:0];
            found = 1'b1;
         end
      end
      return idx;
   endfunction

   function automatic logic [MaxIdxW-1:0] onehot_to_index(input logic [MaxRequesters-1:0] onehot);
      logic [MaxIdxW-1:0] idx;
      idx = '0;
      for (int i = 0; i < MaxRequesters; i++) begin
         if (onehot[i]) idx = idx | i[MaxIdxW-1:0];
      end
      return idx;
   endfunction

endpackage

// File: rtl/br_arb_pri_rr_aging_if.sv
// Request/grant bundle of br_arb_pri_rr_aging; master drives requests, slave is the arbiter.
interface br_arb_pri_rr_aging_if #(
   parameter int NumRequesters = 2,
   parameter int NumPriorities = 2
);
   localparam int PriW = $clog2(NumPriorities);

   logic                                enable_priority_update;
   logic [NumRequesters-1:0]            request;
   logic [NumRequesters-1:0][PriW-1:0]  request_priority;
   logic [NumRequesters-1:0]            grant;
   logic                                grant_promoted;

   modport master (
      output enable_priority_update, request, request_priority,
      input  grant, grant_promoted
   );

   modport slave (
      input  enable_priority_update, request, request_priority,
      output grant, grant_promoted
   );
endinterface

// File: rtl/br_arb_age_counter.sv
// Saturating starvation counter for one requester; promoted while the count sits at AgeThreshold.
module br_arb_age_counter #(
   parameter int AgeThreshold = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic incr,
   output logic promoted
);
   localparam int                AgeW   = $clog2(AgeThreshold + 1);
   localparam logic [AgeW-1:0]   AgeMax = AgeW'(AgeThreshold);

   logic [AgeW-1:0] age;

   // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of block order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                            age <= '0;
      else if (clear)                     age <= '0;
      else if (incr && age != AgeMax)     age <= age + AgeW'(1);
   end

   assign promoted = (age == AgeMax);
endmodule

// File: rtl/br_arb_pri_rr_aging.sv
// Prioritized round-robin arbiter with a pointer per level and optional starvation aging.
// Aging (promoted level, per-requester counters) is built only when BR_ARB_PRI_RR_AGING_EN is defined.
module br_arb_pri_rr_aging
   import br_arb_pkg::*;
#(
   parameter int NumRequesters = 2,
   parameter int NumPriorities = 2,
   parameter int AgeThreshold  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   br_arb_pri_rr_aging_if.slave  arb
);
   localparam int PriW = $clog2(NumPriorities);
   localparam int IdxW = $clog2(NumRequesters);
`ifdef BR_ARB_PRI_RR_AGING_EN
   localparam int NumLevels = NumPriorities + 1;
`else
   localparam int NumLevels = NumPriorities;
`endif
   localparam int              LvlW    = $clog2(NumLevels);
   localparam logic [IdxW-1:0] PtrInit = IdxW'(NumRequesters - 1);

   logic [LvlW-1:0]          eff_lvl [NumRequesters];
   logic [LvlW-1:0]          win_lvl;
   logic [NumRequesters-1:0] level_req;
   logic [NumRequesters-1:0] grant;
   logic [IdxW-1:0]          last_grant [NumLevels];
   logic [MaxIdxW-1:0]       pick_idx;
   logic [MaxIdxW-1:0]       grant_idx_full;
   logic                     unused_idx_bits;

`ifdef BR_ARB_PRI_RR_AGING_EN
   logic [NumRequesters-1:0] promoted;

   for (genvar i = 0; i < NumRequesters; i++) begin : g_age
      br_arb_age_counter #(.AgeThreshold(AgeThreshold)) u_age (
         .clk      (clk),
         .rst      (rst),
         .clear    (arb.enable_priority_update && (grant[i] || !arb.request[i])),
         .incr     (arb.enable_priority_update && arb.request[i] && !grant[i]),
         .promoted (promoted[i])
      );
   end
`endif

   always_comb begin
      for (int i = 0; i < NumRequesters; i++) begin
`ifdef BR_ARB_PRI_RR_AGING_EN
         eff_lvl[i] = promoted[i] ? LvlW'(NumPriorities) : LvlW'(arb.request_priority[i]);
`else
         eff_lvl[i] = LvlW'(arb.request_priority[i]);
`endif
      end
   end

   // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
   always_comb begin
      win_lvl = '0;
      for (int i = 0; i < NumRequesters; i++) begin
         if (arb.request[i] && eff_lvl[i] > win_lvl) win_lvl = eff_lvl[i];
      end
      level_req = '0;
      for (int i = 0; i < NumRequesters; i++) begin
         level_req[i] = arb.request[i] && (eff_lvl[i] == win_lvl);
      end
   end

   always_comb begin
      pick_idx = rr_first_after(MaxRequesters'(level_req), MaxIdxW'(last_grant[win_lvl]),
                                NumRequesters);
      grant    = '0;
      if (!rst && |level_req) grant[pick_idx[IdxW-1:0]] = 1'b1;
   end

   assign grant_idx_full  = onehot_to_index(MaxRequesters'(grant));
   assign unused_idx_bits = ^{pick_idx, grant_idx_full};

   // NOTE: the pointer array is reset because its start value decides the first winner at each level.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int l = 0; l < NumLevels; l++) last_grant[l] <= PtrInit;
      end else if (arb.enable_priority_update && |grant) begin
         last_grant[win_lvl] <= grant_idx_full[IdxW-1:0];
      end
   end

   assign arb.grant = grant;
`ifdef BR_ARB_PRI_RR_AGING_EN
   assign arb.grant_promoted = |grant && (win_lvl == LvlW'(NumPriorities));
`else
   assign arb.grant_promoted = 1'b0;
`endif

   localparam logic [PriW:0] NumPriExt = (PriW + 1)'(NumPriorities);

   assert property (@(posedge clk) NumRequesters >= 2 && NumRequesters <= MaxRequesters &&
                                   NumPriorities >= 2 && AgeThreshold >= 1)
      else $error("br_arb_pri_rr_aging: illegal parameter set");

   for (genvar i = 0; i < NumRequesters; i++) begin : g_prio_chk
      assert property (@(posedge clk) disable iff (rst)
                       arb.request[i] |-> ({1'b0, arb.request_priority[i]} < NumPriExt))
         else $error("br_arb_pri_rr_aging: request %0d has out-of-range priority", i);
   end
endmodule

// File: tb/tb_br_arb_pri_rr_aging.sv
// Scoreboard bench for br_arb_pri_rr_aging (N=4, P=2, AgeThreshold=3); expectations track BR_ARB_PRI_RR_AGING_EN.
module tb_br_arb_pri_rr_aging;
   localparam int N  = 4;
   localparam int P  = 2;
   localparam int TH = 3;
`ifdef BR_ARB_PRI_RR_AGING_EN
   localparam bit Aging = 1'b1;
`else
   localparam bit Aging = 1'b0;
`endif

   typedef struct {
      logic [N-1:0] grant;
      logic         prom;
      string        name;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;
   exp_t sb[$];
   exp_t e;

   br_arb_pri_rr_aging_if #(.NumRequesters(N), .NumPriorities(P)) arb_if ();

   br_arb_pri_rr_aging #(.NumRequesters(N), .NumPriorities(P), .AgeThreshold(TH)) dut (
      .clk (clk),
      .rst (rst),
      .arb (arb_if)
   );

   always #5 clk = ~clk;

   // Drive one cycle at the falling edge, queue its expectation, and stop 2 ns later for sampling.
   task automatic drive(input logic [N-1:0] req, input logic [N-1:0] pri, input logic en,
                        input logic [N-1:0] exp_g, input logic exp_p, input string name);
      @(negedge clk);
      arb_if.request                = req;
      arb_if.request_priority       = pri;
      arb_if.enable_priority_update = en;
      sb.push_back('{grant: exp_g, prom: exp_p, name: name});
      #2;
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst                           = 1'b1;
      arb_if.request                = '0;
      arb_if.enable_priority_update = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset;
      drive(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, "reset_grant");
      e = sb.pop_front();
      compared++;
      if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
         mismatched++;
         $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                  e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
      end
   endtask

   task automatic test_round_robin;
      logic [N-1:0] exp_g [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(4'b1111, 4'b0000, 1'b1, exp_g[i], Aging && (i >= 3), $sformatf("rr_%0d", i));
         e = sb.pop_front();
         compared++;
         if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
            mismatched++;
            $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                     e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
         end
      end
   endtask

   task automatic test_aging;
      logic promo;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         promo = Aging && (i == 3 || i == 7);
         drive(4'b1001, 4'b0001, 1'b1, promo ? 4'b1000 : 4'b0001, promo, $sformatf("aging_%0d", i));
         e = sb.pop_front();
         compared++;
         if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
            mismatched++;
            $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                     e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
         end
      end
   endtask

   task automatic test_level_independence;
      logic [N-1:0] reqs  [6] = '{4'b0110, 4'b1001, 4'b0110, 4'b1001, 4'b1111, 4'b1001};
      logic [N-1:0] exp_g [6] = '{4'b0010, 4'b0001, 4'b0100, 4'b1000, 4'b0010, 4'b0001};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         drive(reqs[i], 4'b0110, 1'b1, exp_g[i], 1'b0, $sformatf("level_%0d", i));
         e = sb.pop_front();
         compared++;
         if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
            mismatched++;
            $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                     e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
         end
      end
   endtask

   task automatic test_update_hold;
      logic promo;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         drive(4'b1111, 4'b0000, 1'b0, 4'b0001, 1'b0, $sformatf("hold_%0d", i));
         e = sb.pop_front();
         compared++;
         if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
            mismatched++;
            $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                     e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
         end
      end
      // Ages held at zero, so promotion needs the full threshold once updates resume.
      for (int i = 0; i < 4; i++) begin
         promo = Aging && (i == 3);
         drive(4'b1001, 4'b0001, 1'b1, promo ? 4'b1000 : 4'b0001, promo,
               $sformatf("hold_resume_%0d", i));
         e = sb.pop_front();
         compared++;
         if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
            mismatched++;
            $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                     e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
         end
      end
   endtask

   task automatic test_reset_mid;
      logic promo;
      do_reset();
      for (int i = 0; i < 2; i++) begin
         drive(4'b0101, 4'b0001, 1'b1, 4'b0001, 1'b0, $sformatf("pre_rst_%0d", i));
         e = sb.pop_front();
         compared++;
         if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
            mismatched++;
            $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                     e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
         end
      end
      #1 rst = 1'b1;
      sb.push_back('{grant: 4'b0000, prom: 1'b0, name: "mid_rst_grant"});
      #1;
      e = sb.pop_front();
      compared++;
      if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
         mismatched++;
         $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                  e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
      end
      arb_if.request = '0;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         promo = Aging && (i == 3);
         drive(4'b0101, 4'b0001, 1'b1, promo ? 4'b0100 : 4'b0001, promo,
               $sformatf("post_rst_%0d", i));
         e = sb.pop_front();
         compared++;
         if (arb_if.grant !== e.grant || arb_if.grant_promoted !== e.prom) begin
            mismatched++;
            $display("FAIL %s: got grant=%b promoted=%b, want grant=%b promoted=%b",
                     e.name, arb_if.grant, arb_if.grant_promoted, e.grant, e.prom);
         end
      end
   endtask

   initial begin
      rst                           = 1'b1;
      arb_if.request                = 4'b1111;
      arb_if.request_priority       = '0;
      arb_if.enable_priority_update = 1'b1;
      test_reset();
      test_round_robin();
      test_aging();
      test_level_independence();
      test_update_hold();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
